instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder. Sequences the PC, issues
//  req/ready reads to instruction memory, and holds the fetched word in the instruction

---
 rtl/instruction_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequences the PC, reads instruction memory over req/ready and holds
// fetched words in an instruction register plus a one-entry skid buffer.
module instruction_fetch_unit #(
  parameter int INSTR_WIDTH = 33,
  parameter int ADDR_WIDTH  = 32,
  parameter int IMM_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_clear,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_ready,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_ir_pc,
  output logic                   o_instr_valid,
  input  logic                   i_instr_accept,
  output logic                   o_irWrite,
  input  logic                   i_redirect_valid,
  input  logic [IMM_WIDTH-1:0]   i_redirect_offset
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_req;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [ADDR_WIDTH-1:0]  r_ir_pc;
  logic                   r_ir_valid;
  logic [INSTR_WIDTH-1:0] r_sb;
  logic [ADDR_WIDTH-1:0]  r_sb_pc;
  logic                   r_sb_valid;
  logic                   r_irwrite;

  state_t                 w_state_next;
  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic                   w_req_next;
  logic [ADDR_WIDTH-1:0]  w_addr_next;
  logic [INSTR_WIDTH-1:0] w_ir_next;
  logic [ADDR_WIDTH-1:0]  w_ir_pc_next;
  logic                   w_ir_valid_next;
  logic [INSTR_WIDTH-1:0] w_sb_next;
  logic [ADDR_WIDTH-1:0]  w_sb_pc_next;
  logic                   w_sb_valid_next;
  logic                   w_ir_load;
  logic                   w_take;

  logic                   w_fire;
  logic                   w_redirect;
  logic                   w_accept;
  logic [ADDR_WIDTH-1:0]  w_off_ext;
  logic [ADDR_WIDTH-1:0]  w_target;

  assign w_fire     = r_req & i_imem_ready;
  assign w_redirect = i_redirect_valid & r_ir_valid;
  assign w_accept   = i_instr_accept & r_ir_valid & ~w_redirect;
  assign w_off_ext  = {{(ADDR_WIDTH-IMM_WIDTH){i_redirect_offset[IMM_WIDTH-1]}}, i_redirect_offset};
  assign w_target   = r_ir_pc + (w_off_ext << 2);

  // A redirect flushes both buffers; a read still in flight is drained and dropped.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_pc_next    = r_ir_pc;
    w_ir_valid_next = r_ir_valid;
    w_sb_next       = r_sb;
    w_sb_pc_next    = r_sb_pc;
    w_sb_valid_next = r_sb_valid;
    w_ir_load       = 1'b0;
    w_take          = (r_state == FETCH) & w_fire;

    if (w_redirect) begin
      w_ir_valid_next = 1'b0;
      w_sb_valid_next = 1'b0;
      w_pc_next       = w_target;
      case (r_state)
        FETCH:   w_state_next = w_fire ? FETCH : DRAIN;
        HOLD:    w_state_next = FETCH;
        default: w_state_next = r_state;
      endcase
    end else if (r_state == DRAIN) begin
      if (w_fire) w_state_next = FETCH;
    end else begin
      if (w_take) w_pc_next = r_pc + ADDR_WIDTH'(4);
      if (w_accept) begin
        if (r_sb_valid) begin
          w_ir_next       = r_sb;
          w_ir_pc_next    = r_sb_pc;
          w_ir_load       = 1'b1;
          w_sb_valid_next = 1'b0;
          if (w_take) begin
            w_sb_next       = i_imem_rdata;
            w_sb_pc_next    = r_addr;
            w_sb_valid_next = 1'b1;
          end
        end else if (w_take) begin
          w_ir_next    = i_imem_rdata;
          w_ir_pc_next = r_addr;
          w_ir_load    = 1'b1;
        end else begin
          w_ir_valid_next = 1'b0;
        end
      end else if (w_take) begin
        if (!r_ir_valid) begin
          w_ir_next    = i_imem_rdata;
          w_ir_pc_next = r_addr;
          w_ir_load    = 1'b1;
        end else begin
          w_sb_next       = i_imem_rdata;
          w_sb_pc_next    = r_addr;
          w_sb_valid_next = 1'b1;
        end
      end
      if (w_ir_load) w_ir_valid_next = 1'b1;
      w_state_next = (w_ir_valid_next & w_sb_valid_next) ? HOLD : FETCH;
    end

    // Request drops for one cycle after every completed read; address is frozen while pending.
    w_req_next  = (w_state_next != HOLD) & ~w_fire;
    w_addr_next = (r_req & ~w_fire) ? r_addr : w_pc_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_sb       <= '0;
      r_sb_pc    <= '0;
      r_sb_valid <= 1'b0;
      r_irwrite  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_ir       <= w_ir_next;
      r_ir_pc    <= w_ir_pc_next;
      r_ir_valid <= w_ir_valid_next;
      r_sb       <= w_sb_next;
      r_sb_pc    <= w_sb_pc_next;
      r_sb_valid <= w_sb_valid_next;
      r_irwrite  <= w_ir_load;
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instruction = r_ir;
  assign o_ir_pc       = r_ir_pc;
  assign o_instr_valid = r_ir_valid;
  assign o_irWrite     = r_irwrite;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: program-order scoreboard against a memory model
// whose words are a fixed function of the address.
module tb_instruction_fetch_unit;
  localparam int IW = 33;
  localparam int AW = 32;
  localparam int MW = 12;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          imemReady = 1'b0;
  logic [IW-1:0] imemRdata = '0;
  logic [IW-1:0] instruction;
  logic [AW-1:0] irPc;
  logic          instrValid;
  logic          instrAccept = 1'b0;
  logic          irWrite;
  logic          redirectValid = 1'b0;
  logic [MW-1:0] redirectOffset = '0;

  int total = 0;
  int bad = 0;
  logic [AW-1:0] expQ[$];
  int  memLat = 1;
  bit  memRand = 1'b0;
  int  waitCnt = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .IMM_WIDTH(MW), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_clear(clear),
    .o_imem_req(imemReq), .o_imem_addr(imemAddr),
    .i_imem_ready(imemReady), .i_imem_rdata(imemRdata),
    .o_instruction(instruction), .o_ir_pc(irPc), .o_instr_valid(instrValid),
    .i_instr_accept(instrAccept), .o_irWrite(irWrite),
    .i_redirect_valid(redirectValid), .i_redirect_offset(redirectOffset)
  );

  function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = (a * 32'h9E3779B1) ^ 32'h13579BDF;
    return {^a, h};
  endfunction

  function automatic int nextLat();
    if (memRand) return int'($urandom_range(memLat, 0));
    return memLat;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: answers a request after waitCnt cycles, drives garbage data otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      imemRdata = IW'({$urandom(), $urandom()});
      if (!clear) begin
        imemReady = 1'b0;
        waitCnt   = nextLat();
      end else if (imemReq) begin
        if (waitCnt == 0) begin
          imemReady = 1'b1;
          imemRdata = memWord(imemAddr);
          waitCnt   = nextLat();
        end else begin
          imemReady = 1'b0;
          waitCnt--;
        end
      end else begin
        imemReady = 1'b0;
      end
    end
  end

  // Monitor: every irWrite pulse must present the next word in program order.
  initial begin
    bit            prevPending;
    logic [AW-1:0] prevAddr;
    logic [AW-1:0] e;
    prevPending = 1'b0;
    prevAddr    = '0;
    forever begin
      @(negedge clk);
      if (clear) begin
        if (prevPending)
          checkOutput("addr_stable", 64'({imemReq, imemAddr}), 64'({1'b1, prevAddr}));
        if (irWrite) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_irwrite", 64'(irPc), 64'hDEAD);
          end else begin
            e = expQ.pop_front();
            checkOutput("ir_pc", 64'(irPc), 64'(e));
            checkOutput("instruction", 64'(instruction), 64'(memWord(e)));
            checkOutput("valid_on_irwrite", 64'(instrValid), 64'd1);
          end
        end
      end
      prevPending = clear && imemReq && !imemReady;
      prevAddr    = imemAddr;
    end
  end

  // One clock of stimulus; called and returns at a falling edge.
  task automatic applyStimulus(input bit acc, input bit red, input logic [MW-1:0] off, input bit clr);
    logic [AW-1:0] offExt;
    #1;
    offExt = {{(AW-MW){off[MW-1]}}, off};
    if (clr) begin
      expQ.delete();
      expQ.push_back(RESET_PC);
    end else if (instrValid) begin
      if (red) expQ.push_back(irPc + (offExt << 2));
      else if (acc) expQ.push_back(irPc + 32'd4);
    end
    instrAccept    = acc;
    redirectValid  = red;
    redirectOffset = off;
    clear          = !clr;
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"}, 64'(imemReq), 64'd0);
    checkOutput({tag, "_addr"}, 64'(imemAddr), 64'(RESET_PC));
    checkOutput({tag, "_instr"}, 64'(instruction), 64'd0);
    checkOutput({tag, "_irpc"}, 64'(irPc), 64'd0);
    checkOutput({tag, "_valid"}, 64'(instrValid), 64'd0);
    checkOutput({tag, "_irwrite"}, 64'(irWrite), 64'd0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, '0, 1);
    applyStimulus(0, 0, '0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0);
  endtask

  task automatic waitIr(input logic [AW-1:0] pc, input string name);
    int i;
    for (i = 0; i < 100 && !(instrValid && irPc == pc); i++) applyStimulus(0, 0, '0, 0);
    checkOutput(name, 64'(instrValid && irPc == pc), 64'd1);
  endtask

  function automatic logic [MW-1:0] offTo(input logic [AW-1:0] from, input logic [AW-1:0] to);
    logic [AW-1:0] d;
    d = to - from;
    return d[MW+1:2];
  endfunction

  initial begin
    int drainCycles;
    @(negedge clk);

    // Streaming with accept every cycle
    memLat = 1; memRand = 1'b0;
    doReset();
    checkResetState("reset");
    applyStimulus(0, 0, '0, 0);
    checkOutput("req_after_release", 64'({imemReq, imemAddr}), 64'({1'b1, RESET_PC}));
    for (int i = 0; i < 40; i++) applyStimulus(1, 0, '0, 0);

    // Hold with accept low, then a single accept
    memLat = 0;
    doReset();
    idle(20);
    checkOutput("hold_req", 64'(imemReq), 64'd0);
    checkOutput("hold_irpc", 64'(irPc), 64'd0);
    checkOutput("hold_instr", 64'(instruction), 64'(memWord(32'd0)));
    applyStimulus(1, 0, '0, 0);
    checkOutput("sb_to_ir_pc", 64'(irPc), 64'd4);
    checkOutput("sb_to_ir_irwrite", 64'(irWrite), 64'd1);
    checkOutput("resume_addr", 64'({imemReq, imemAddr}), 64'({1'b1, 32'h8}));

    // Redirect from HOLD with a negative offset
    applyStimulus(0, 1, offTo(irPc, 32'h40), 0);
    waitIr(32'h40, "reach_0x40");
    idle(10);
    applyStimulus(0, 1, 12'hFFE, 0);
    checkOutput("redir_valid_low", 64'(instrValid), 64'd0);
    checkOutput("redir_addr", 64'({imemReq, imemAddr}), 64'({1'b1, 32'h38}));
    waitIr(32'h38, "reach_0x38");

    // Redirect while a read is pending: drain the stale read
    memLat = 3;
    applyStimulus(0, 1, offTo(irPc, 32'h40), 0);
    waitIr(32'h40, "reach_0x40_again");
    for (int i = 0; i < 20 && !(imemReq && imemAddr == 32'h44 && !imemReady); i++) idle(1);
    checkOutput("pending_0x44", 64'(imemReq && imemAddr == 32'h44 && !imemReady), 64'd1);
    applyStimulus(0, 1, 12'd8, 0);
    drainCycles = 0;
    for (int i = 0; i < 20 && !(imemReq && imemAddr == 32'h60); i++) begin
      if (imemReq && imemAddr == 32'h44) drainCycles++;
      idle(1);
    end
    checkOutput("drain_seen", 64'(drainCycles > 0), 64'd1);
    checkOutput("drain_target", 64'({imemReq, imemAddr}), 64'({1'b1, 32'h60}));
    waitIr(32'h60, "reach_0x60");

    // Redirect beats accept; redirect ignored with no valid instruction
    applyStimulus(1, 1, 12'd16, 0);
    checkOutput("redir_beats_accept", 64'(instrValid), 64'd0);
    applyStimulus(1, 1, 12'd5, 0);
    waitIr(32'hA0, "reach_0xa0");

    // Wrap-around through the top of the address space
    memLat = 1;
    doReset();
    applyStimulus(0, 0, '0, 0);
    waitIr(32'h0, "wrap_start");
    applyStimulus(0, 1, 12'hFFF, 0);
    waitIr(32'hFFFF_FFFC, "reach_top");
    applyStimulus(1, 0, '0, 0);
    waitIr(32'h0, "wrap_to_zero");

    // Reset mid-read and in HOLD
    memLat = 3;
    for (int i = 0; i < 20 && !(imemReq && !imemReady); i++) idle(1);
    doReset();
    checkResetState("reset_midread");
    applyStimulus(0, 0, '0, 0);
    memLat = 0;
    idle(20);
    checkOutput("hold_before_reset", 64'({imemReq, instrValid}), 64'({1'b0, 1'b1}));
    doReset();
    checkResetState("reset_hold");

    // Randomized traffic
    memRand = 1'b1; memLat = 3;
    applyStimulus(0, 0, '0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit clr;
      clr = ($urandom_range(399, 0) == 0);
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, MW'($urandom()), clr);
      if (clr) checkResetState("rand_reset");
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
